fifo_wr_arb: RTL and testbench

Round-robin write-port arbiter that shares the write side of one FIFO (`winc`/`wdata`/`wfull`) among `NREQ` requesters. Each requester presents a valid/data stream. The arbiter grants one requester at a time for a burst of up to `BURST` beats and forwards its data into the FIFO, with back-pressure taken from `wfull`. It sits in the FIFO's write clock domain and is the only agent that drives `winc`.

---
 rtl/fifo_wr_arb_if.sv | 23 ++
 rtl/fifo_wr_arb.sv | 84 ++++++++
 tb/tb_fifo_wr_arb.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if: requester streams and FIFO write-side signals shared by the arbiter
interface fifo_wr_arb_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [NREQ-1:0]       grant;
    logic [IDW-1:0]        grant_id;
    modport master (
        input  req_valid, req_data, wfull,
        output req_ready, winc, wdata, grant, grant_id
    );
    modport slave (
        output req_valid, req_data, wfull,
        input  req_ready, winc, wdata, grant, grant_id
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter sharing one FIFO write port among NREQ requesters
module fifo_wr_arb #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input logic            clk,
    input logic            resetb,
    fifo_wr_arb_if.master  bus
);
    localparam int BW = $clog2(BURST + 1);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t          state_q, state_d;
    logic [IDW-1:0]  cur_q, cur_d, last_q, last_d;
    logic [BW-1:0]   beats_q, beats_d;
    logic            xfer, burst_end;
    logic [NREQ-1:0] masked;
    function automatic logic [IDW-1:0] pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] from);
        logic [IDW-1:0] r;
        int idx;
        r = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(from) + k) % NREQ;
            if (v[idx]) r = IDW'(idx);
        end
        return r;
    endfunction
    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        last_d        = last_q;
        beats_d       = beats_q;
        xfer          = 1'b0;
        burst_end     = 1'b0;
        masked        = '0;
        bus.req_ready = '0;
        bus.winc      = 1'b0;
        bus.wdata     = '0;
        bus.grant     = '0;
        bus.grant_id  = '0;
        if (state_q == IDLE) begin
            if (|bus.req_valid) begin
                state_d = GRANT;
                cur_d   = pick(bus.req_valid, last_q);
                last_d  = cur_d;
                beats_d = '0;
            end
        end else begin
            xfer                 = bus.req_valid[cur_q] & ~bus.wfull;
            burst_end            = xfer && (beats_q == BW'(BURST - 1));
            // a beat in flight while reset is low is dropped rather than half-accepted
            bus.req_ready[cur_q] = resetb & ~bus.wfull;
            bus.winc             = resetb & xfer;
            bus.wdata            = bus.req_data[cur_q*DSIZE +: DSIZE];
            bus.grant[cur_q]     = 1'b1;
            bus.grant_id         = cur_q;
            beats_d              = xfer ? beats_q + BW'(1) : beats_q;
            if (burst_end || !bus.req_valid[cur_q]) begin
                masked  = bus.req_valid & ~(NREQ'(1) << cur_q);
                beats_d = '0;
                if (|masked) begin
                    cur_d  = pick(masked, last_q);
                    last_d = cur_d;
                end else if (!burst_end) begin
                    state_d = IDLE;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q <= IDLE;
            cur_q   <= '0;
            last_q  <= IDW'(NREQ - 1);
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed plus randomized check of fifo_wr_arb against an owner/burst-count model
module tb_fifo_wr_arb;
    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;
    localparam int IDW   = 2;
    typedef struct {int id; int data; int cyc;} ent_t;
    logic clk = 1'b0;
    logic resetb = 1'b0;
    fifo_wr_arb_if #(.NREQ(NREQ), .DSIZE(DSIZE), .IDW(IDW)) bus ();
    fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST), .IDW(IDW)) dut (
        .clk(clk), .resetb(resetb), .bus(bus.master)
    );
    always #5 clk = ~clk;
    int n_pass = 0, n_total = 0;
    int m_owner = -1, m_last = NREQ - 1, m_beats = 0, cyc = 0;
    bit started = 0;
    logic [NREQ-1:0] acc = '0;
    int rem [NREQ];
    logic [DSIZE-1:0] dval [NREQ];
    ent_t wlog [$];
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, got, exp, cyc);
    endtask
    function automatic int rr(input logic [NREQ-1:0] v, input int from);
        for (int k = 1; k <= NREQ; k++) if (v[(from + k) % NREQ]) return (from + k) % NREQ;
        return -1;
    endfunction
    function automatic int count_id(input int id);
        int n = 0;
        foreach (wlog[k]) if (wlog[k].id == id) n++;
        return n;
    endfunction
    // model: who owns the port and how many beats it has moved in the current grant
    task automatic model_step();
        logic [NREQ-1:0] v, others;
        bit x, done;
        v = bus.req_valid;
        acc = '0;
        started = 1;
        cyc++;
        if (!resetb) begin
            m_owner = -1; m_last = NREQ - 1; m_beats = 0;
        end else if (m_owner < 0) begin
            if (v != 0) begin m_owner = rr(v, m_last); m_last = m_owner; m_beats = 0; end
        end else begin
            x = v[m_owner] && !bus.wfull;
            acc[m_owner] = x;
            if (x) m_beats++;
            done = x && m_beats == BURST;
            if (done || !v[m_owner]) begin
                others = v;
                others[m_owner] = 1'b0;
                m_beats = 0;
                if (others != 0) begin m_owner = rr(others, m_last); m_last = m_owner; end
                else if (!done) m_owner = -1;
            end
        end
    endtask
    task automatic compare();
        logic [NREQ-1:0] eg, er;
        logic [DSIZE-1:0] ed;
        int eid;
        logic ew;
        eg = '0; er = '0; ed = '0; eid = 0; ew = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            eid = m_owner;
            ed = bus.req_data[m_owner*DSIZE +: DSIZE];
            er[m_owner] = resetb && !bus.wfull;
            ew = er[m_owner] && bus.req_valid[m_owner];
        end
        chk("grant", 32'(bus.grant), 32'(eg));
        chk("grant_id", 32'(bus.grant_id), eid);
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        chk("winc", 32'(bus.winc), 32'(ew));
        chk("wdata", 32'(bus.wdata), 32'(ed));
        chk("winc_vs_wfull", 32'(bus.winc & bus.wfull), 0);
        if (bus.winc === 1'b1) wlog.push_back('{int'(bus.grant_id), int'(bus.wdata), cyc});
    endtask
    initial forever begin @(posedge clk); model_step(); end
    initial forever begin @(negedge clk); if (started) compare(); end
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = rem[i] > 0;
            bus.req_data[i*DSIZE +: DSIZE] = dval[i];
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (acc[i]) begin rem[i]--; dval[i]++; end
        drive();
    endtask
    task automatic do_reset();
        resetb = 1'b0;
        bus.wfull = 1'b0;
        for (int i = 0; i < NREQ; i++) begin rem[i] = 0; dval[i] = DSIZE'(i * 16); end
        drive();
        step();
        step();
        resetb = 1'b1;
        wlog.delete();
    endtask
    initial begin
        int exp_ids [8] = '{1, 1, 1, 1, 2, 2, 1, 1};
        bus.wfull = 1'b0;
        for (int i = 0; i < NREQ; i++) begin rem[i] = 3; dval[i] = DSIZE'(i * 16); end
        drive();
        // reset with every requester valid
        repeat (2) begin
            step();
            chk("rst_winc", 32'(bus.winc), 0);
            chk("rst_grant", 32'(bus.grant), 0);
        end
        resetb = 1'b1;
        step();
        chk("first_grant", 32'(bus.grant), 32'h1);
        chk("first_grant_id", 32'(bus.grant_id), 0);
        // single requester streaming across a burst boundary
        do_reset();
        rem[2] = 6; dval[2] = 8'h10;
        drive();
        repeat (12) step();
        chk("stream_count", wlog.size(), 6);
        foreach (wlog[k]) begin
            chk("stream_id", wlog[k].id, 2);
            chk("stream_data", wlog[k].data, 32'h10 + k);
            chk("stream_cyc", wlog[k].cyc - wlog[0].cyc, k);
        end
        // full contention
        do_reset();
        rem[0] = 8; rem[1] = 4; rem[2] = 4; rem[3] = 4;
        drive();
        repeat (24) step();
        chk("cont_count", wlog.size(), 20);
        if (wlog.size() == 20) begin
            chk("cont_span", wlog[19].cyc - wlog[0].cyc, 19);
            foreach (wlog[k]) chk("cont_order", wlog[k].id, (k / 4) % 4);
        end
        // back-pressure mid-burst of requester 1
        do_reset();
        rem[1] = 6; rem[2] = 2;
        drive();
        repeat (3) step();
        bus.wfull = 1'b1;
        repeat (3) begin
            #1;
            chk("stall_winc", 32'(bus.winc), 0);
            chk("stall_ready", 32'(bus.req_ready), 0);
            chk("stall_grant", 32'(bus.grant), 32'h2);
            step();
        end
        bus.wfull = 1'b0;
        repeat (12) step();
        chk("bp_count", wlog.size(), 8);
        if (wlog.size() == 8) foreach (wlog[k]) chk("bp_order", wlog[k].id, exp_ids[k]);
        // early release by requester 3
        do_reset();
        rem[3] = 8;
        drive();
        step();
        rem[0] = 4;
        drive();
        step();
        step();
        rem[3] = 0;
        drive();
        step();
        chk("early_grant", 32'(bus.grant), 32'h1);
        repeat (8) step();
        chk("early_r3_writes", count_id(3), 2);
        chk("early_r0_writes", count_id(0), 4);
        // reset during requester 1's third beat
        do_reset();
        rem[1] = 8;
        drive();
        repeat (3) step();
        resetb = 1'b0;
        rem[2] = 4;
        drive();
        #1;
        chk("midrst_winc", 32'(bus.winc), 0);
        step();
        chk("midrst_winc2", 32'(bus.winc), 0);
        chk("midrst_grant", 32'(bus.grant), 0);
        step();
        chk("midrst_r1_writes", count_id(1), 2);
        resetb = 1'b1;
        step();
        chk("midrst_regrant", 32'(bus.grant), 32'h2);
        chk("midrst_regrant_id", 32'(bus.grant_id), 1);
        // randomized traffic, back-pressure and occasional reset
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rem[i] == 0 && $urandom_range(7) == 0) rem[i] = int'($urandom_range(9, 1));
                else if (rem[i] > 0 && $urandom_range(40) == 0) rem[i] = 0;
            end
            bus.wfull = ($urandom_range(3) == 0);
            resetb = !($urandom_range(600) == 0);
            drive();
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
